// File: rtl/pool_layer_stream.sv
// pool_layer_stream: streaming 2x2 / stride-2 pooling layer (average or max).
// Raster-order pixels in, raster-order pooled pixels out, valid/ready on both sides.
// Optional build macro: POOL_RELU_EN clamps negative pooled lanes to zero.
//
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | accepting input pixels of the frame
//   DRAIN | all input taken, waiting for the last pooled beat to leave
//   DONE  | one-cycle frame-end pulse
module pool_layer_stream #(
  parameter int DATA_W = 8,
  parameter int CH     = 1,
  parameter int FM_W   = 6,
  parameter int FM_H   = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 mode,
  input  logic [CH*DATA_W-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [CH*DATA_W-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done
);

  localparam int HALF_W = FM_W / 2;
  localparam int COL_W  = (FM_W > 2) ? $clog2(FM_W) : 1;
  localparam int ROW_W  = (FM_H > 2) ? $clog2(FM_H) : 1;
  localparam int PIDX_W = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [COL_W-1:0]         col_q;
  logic [ROW_W-1:0]         row_q;
  logic                     mode_q;
  logic [CH*DATA_W-1:0]     out_data_q;
  logic                     out_valid_q;

  logic signed [DATA_W-1:0] pair_q [CH];
  logic signed [DATA_W:0]   part_q [HALF_W][CH];

  logic                     accept;
  logic                     last_col, last_row;
  logic [PIDX_W-1:0]        pidx;
  logic [CH*(DATA_W+1)-1:0] pair_res;
  logic [CH*DATA_W-1:0]     pool_res;

  assign in_ready  = (state_q == S_RUN) && (!out_valid_q || out_ready);
  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

  assign accept   = in_valid && in_ready;
  assign last_col = (col_q == COL_W'(FM_W - 1));
  assign last_row = (row_q == ROW_W'(FM_H - 1));
  assign pidx     = PIDX_W'(col_q >> 1);

  // Per-lane arithmetic: pair combine for even rows, 4-pixel pool for odd rows.
  for (genvar c = 0; c < CH; c++) begin : g_lane
    logic signed [DATA_W-1:0] px;
    logic signed [DATA_W:0]   px_e, pair_e, part_e, m1, m2;
    logic signed [DATA_W+1:0] sum4;
    logic signed [DATA_W-1:0] avg_v, max_v, pre_v;

    assign px     = in_data[c*DATA_W +: DATA_W];
    assign px_e   = {px[DATA_W-1], px};
    assign pair_e = {pair_q[c][DATA_W-1], pair_q[c]};
    assign part_e = part_q[pidx][c];

    assign pair_res[c*(DATA_W+1) +: DATA_W+1] =
      mode_q ? ((pair_e > px_e) ? pair_e : px_e) : (pair_e + px_e);

    // Partial already holds two pixels; one extra sign bit covers all four.
    assign sum4  = {part_e[DATA_W], part_e} + {px_e[DATA_W], px_e} + {pair_e[DATA_W], pair_e};
    assign avg_v = DATA_W'(sum4 >>> 2);
    assign m1    = (part_e > pair_e) ? part_e : pair_e;
    assign m2    = (m1 > px_e) ? m1 : px_e;
    assign max_v = DATA_W'(m2);
    assign pre_v = mode_q ? max_v : avg_v;

`ifdef POOL_RELU_EN
    assign pool_res[c*DATA_W +: DATA_W] = pre_v[DATA_W-1] ? '0 : pre_v;
`else
    assign pool_res[c*DATA_W +: DATA_W] = pre_v;
`endif
  end

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (accept && last_col && last_row) state_d = S_DRAIN;
      S_DRAIN: if (!out_valid_q || out_ready) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers: state, raster counters, latched mode, output beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      mode_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        col_q  <= '0;
        row_q  <= '0;
        mode_q <= mode;
      end else if (accept) begin
        if (last_col) begin
          col_q <= '0;
          row_q <= row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
      if (accept && row_q[0] && col_q[0]) begin
        out_data_q  <= pool_res;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Line buffer and pair register; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (!col_q[0]) begin
        for (int c = 0; c < CH; c++) pair_q[c] <= in_data[c*DATA_W +: DATA_W];
      end else if (!row_q[0]) begin
        for (int c = 0; c < CH; c++) part_q[pidx][c] <= pair_res[c*(DATA_W+1) +: DATA_W+1];
      end
    end
  end

endmodule
